// File: rtl/cordic_vectoring.sv
// Pipelined-in-time CORDIC vectoring engine: (x, y) Q2.14 -> magnitude and atan2 angle, Q4.14.
// Define GAIN_COMP_EN to add a one-cycle 1/K multiply so mag_out approximates the true magnitude.
module cordic_vectoring #(
   parameter int DATA_WIDTH = 16,
   parameter int ITER       = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] x_in,
   input  logic signed [DATA_WIDTH-1:0] y_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH+1:0] mag_out,
   output logic signed [DATA_WIDTH+1:0] ang_out
);

   localparam int W = DATA_WIDTH + 2;

   // atan(2^-i) in Q2.14; entry i sits at bits [16*i +: 16]
   localparam logic [255:0] ATAN_TAB = {
      16'h0001, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
      16'h0080, 16'h0100, 16'h0200, 16'h03FF, 16'h07F5, 16'h0FAE, 16'h1DAC, 16'h3244
   };
   localparam logic signed [W-1:0] PI_POS = W'(51472);
   localparam logic signed [W-1:0] PI_NEG = -PI_POS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
`ifdef GAIN_COMP_EN
      S_COMP = 2'd3,
`endif
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic signed [W-1:0] r_x, r_y, r_z;
   logic signed [W-1:0] r_mag, r_ang;
   logic [3:0]          r_iter;
   logic                r_zero;

   logic signed [W-1:0] w_atan [16];
   logic signed [W-1:0] w_x_ext, w_y_ext;
   logic signed [W-1:0] w_x_pre, w_y_pre, w_z_pre;
   logic signed [W-1:0] w_x_sh, w_y_sh;
   logic signed [W-1:0] w_x_nx, w_y_nx, w_z_nx;
   logic                w_dir_neg;
   logic                w_last;
   logic                w_accept;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_atan
         assign w_atan[gi] = W'(ATAN_TAB[gi*16 +: 16]);
      end
   endgenerate

   assign w_x_ext  = {{2{x_in[DATA_WIDTH-1]}}, x_in};
   assign w_y_ext  = {{2{y_in[DATA_WIDTH-1]}}, y_in};
   assign w_last   = (r_iter == 4'(ITER - 1));
   assign w_accept = in_valid & in_ready;

   // Left half-plane operands are rotated by pi first; negation happens in the extended width
   always_comb begin
      w_x_pre = w_x_ext;
      w_y_pre = w_y_ext;
      w_z_pre = '0;
      if (x_in[DATA_WIDTH-1]) begin
         w_x_pre = -w_x_ext;
         w_y_pre = -w_y_ext;
         w_z_pre = y_in[DATA_WIDTH-1] ? PI_NEG : PI_POS;
      end
   end

   assign w_dir_neg = r_y[W-1];
   assign w_x_sh    = r_x >>> r_iter;
   assign w_y_sh    = r_y >>> r_iter;
   assign w_x_nx    = w_dir_neg ? (r_x - w_y_sh) : (r_x + w_y_sh);
   assign w_y_nx    = w_dir_neg ? (r_y + w_x_sh) : (r_y - w_x_sh);
   assign w_z_nx    = w_dir_neg ? (r_z - w_atan[r_iter]) : (r_z + w_atan[r_iter]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
`ifdef GAIN_COMP_EN
               w_state_next = S_COMP;
`else
               w_state_next = S_DONE;
`endif
            end
         end
`ifdef GAIN_COMP_EN
         S_COMP: begin
            w_state_next = S_DONE;
         end
`endif
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

`ifdef GAIN_COMP_EN
   localparam logic signed [W-1:0]   GAIN_INV = W'(39797);
   localparam logic signed [2*W-1:0] GAIN_RND = (2*W)'(32768);
   logic signed [2*W-1:0] w_prod;
   assign w_prod = r_x * GAIN_INV;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_iter <= '0;
         r_zero <= 1'b0;
         r_mag  <= '0;
         r_ang  <= '0;
      end else if (w_accept) begin
         r_x    <= w_x_pre;
         r_y    <= w_y_pre;
         r_z    <= w_z_pre;
         r_iter <= '0;
         r_zero <= (x_in == '0) && (y_in == '0);
      end else if (r_state == S_RUN) begin
         r_x    <= w_x_nx;
         r_y    <= w_y_nx;
         r_z    <= w_z_nx;
         r_iter <= r_iter + 4'd1;
`ifndef GAIN_COMP_EN
         // A zero vector never steers y, so z would collect every table entry; report 0 instead
         if (w_last) begin
            r_mag <= w_x_nx;
            r_ang <= r_zero ? '0 : w_z_nx;
         end
`endif
      end
`ifdef GAIN_COMP_EN
      else if (r_state == S_COMP) begin
         r_mag <= W'((w_prod + GAIN_RND) >>> 16);
         r_ang <= r_zero ? '0 : r_z;
      end
`endif
   end

   assign mag_out = r_mag;
   assign ang_out = r_ang;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: driver pushes expected results, monitor pops on output handshake.
module tb_cordic_vectoring;
   localparam int DW   = 16;
   localparam int ITER = 16;
`ifdef GAIN_COMP_EN
   localparam int LAT  = ITER + 1;
   localparam bit COMP = 1'b1;
`else
   localparam int LAT  = ITER;
   localparam bit COMP = 1'b0;
`endif
   localparam int NV = 9;

   // x, y, angle, mag (uncompensated), mag (compensated), angle tol, mag tol, stall cycles
   localparam int VX [NV] = '{'h4000, 'h4000, 'hC000, 0,      0, 'h8000, 'h4000, 0,     'hC000};
   localparam int VY [NV] = '{0,      'h4000, 0,      'hC000, 0, 0,      'hC000, 'h4000, 'hC000};
   localparam int VA [NV] = '{0,      12868,  51472, -25736,  0, 51472, -12868,  25736, -38604};
   localparam int VMN[NV] = '{26981,  38156,  26981,  26981,  0, 53961,  38156,  26981,  38156};
   localparam int VMC[NV] = '{16384,  23170,  16384,  16384,  0, 32768,  23170,  16384,  23170};
   localparam int VTA[NV] = '{4,      4,      4,      4,      0, 6,      6,      6,      6};
   localparam int VTM[NV] = '{8,      12,     12,     12,     0, 16,     12,     12,     12};
   localparam int VST[NV] = '{0,      0,      0,      0,      0, 0,      5,      0,      0};

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] x_in, y_in;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW+1:0] mag_out, ang_out;

   typedef struct {
      int id;
      int ang;
      int mag;
      int ta;
      int tm;
      int stall;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   fails = 0;
   int   cyc   = 0;

   cordic_vectoring #(.DATA_WIDTH(DW), .ITER(ITER)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
      .mag_out(mag_out), .ang_out(ang_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp, input int tol);
      int d;
      total++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
      end
   endtask

   // Present vector i (called right after a negedge); returns on the negedge after the accept edge
   task automatic send(input int i);
      int   n;
      exp_t e;
      x_in     = DW'(VX[i]);
      y_in     = DW'(VY[i]);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk($sformatf("v%0d accept timeout", i), 0, 1, 0);
         in_valid = 1'b0;
         return;
      end
      e.id    = i;
      e.ang   = VA[i];
      e.mag   = COMP ? VMC[i] : VMN[i];
      e.ta    = VTA[i];
      e.tm    = VTM[i];
      e.stall = VST[i];
      e.acc   = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain timeout", sb.size(), 0, 0);
         sb.delete();
      end
   endtask

   // Monitor / sink: owns out_ready
   initial begin
      bit seen;
      bit chk_rdy;
      int stall_left;
      int snap_mag, snap_ang;
      seen = 0; chk_rdy = 0; stall_left = 0; snap_mag = 0; snap_ang = 0;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 0; chk_rdy = 0; stall_left = 0;
            out_ready = 1'b1;
         end else if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected out_valid", 1, 0, 0);
            end else begin
               if (!seen) begin
                  seen = 1;
                  chk($sformatf("v%0d latency", sb[0].id), cyc - sb[0].acc, LAT, 0);
                  snap_mag   = int'(mag_out);
                  snap_ang   = int'(ang_out);
                  stall_left = sb[0].stall;
               end else begin
                  chk($sformatf("v%0d mag stable", sb[0].id), int'(mag_out), snap_mag, 0);
                  chk($sformatf("v%0d ang stable", sb[0].id), int'(ang_out), snap_ang, 0);
                  chk($sformatf("v%0d in_ready busy", sb[0].id), int'(in_ready), 0, 0);
               end
               if (stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else begin
                  out_ready = 1'b1;
                  chk($sformatf("v%0d mag", sb[0].id), int'(mag_out), sb[0].mag, sb[0].tm);
                  chk($sformatf("v%0d ang", sb[0].id), int'(ang_out), sb[0].ang, sb[0].ta);
                  $display("txn v%0d: mag=%0d (exp %0d) ang=%0d (exp %0d)",
                           sb[0].id, int'(mag_out), sb[0].mag, int'(ang_out), sb[0].ang);
                  void'(sb.pop_front());
                  seen    = 0;
                  chk_rdy = 1;
               end
            end
         end else if (chk_rdy) begin
            chk("in_ready after transfer", int'(in_ready), 1, 0);
            chk_rdy = 0;
         end
      end
   end

   // Driver
   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      x_in     = '0;
      y_in     = '0;
      repeat (3) @(negedge clk);
      chk("reset out_valid", int'(out_valid), 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset in_ready", int'(in_ready), 1, 0);
      chk("reset out_valid after release", int'(out_valid), 0, 0);
      chk("reset mag_out", int'(mag_out), 0, 0);
      chk("reset ang_out", int'(ang_out), 0, 0);

      // Back-to-back: in_valid stays high with the next operands while the block is busy
      for (int i = 0; i < NV; i++) send(i);
      in_valid = 1'b0;
      drain();

      // Abort mid-run with an asynchronous reset at iteration 7
      send(1);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      void'(sb.pop_back());
      #2 rst_n = 1'b0;
      #1;
      chk("abort out_valid", int'(out_valid), 0, 0);
      chk("abort in_ready", int'(in_ready), 1, 0);
      chk("abort mag_out", int'(mag_out), 0, 0);
      chk("abort ang_out", int'(ang_out), 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-abort in_ready", int'(in_ready), 1, 0);
      repeat (LAT + 4) @(negedge clk);
      send(0);
      in_valid = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/cordic_vectoring.md
CORDIC_VECTORING -- requirements
Module: cordic_vectoring

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of input operands x_in/y_in (signed, Q2.14).
REQ-002 SHALL have parameter ITER, default 16, number of CORDIC micro-rotations (1..16).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports x_in, y_in  input  DATA_WIDTH each  signed Cartesian operands.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port mag_out  output  DATA_WIDTH+2  signed magnitude, Q4.14.
REQ-011 SHALL have port ang_out  output  DATA_WIDTH+2  signed angle in radians, Q4.14, range [-pi, +pi].

Function
REQ-012 SHALL hold an internal 16-entry arctan table, index i = atan(2^-i) Q2.14: 3244,1DAC,0FAE,07F5,03FF,0200,0100,0080,0040,0020,0010,0008,0004,0002,0001,0001 (hex).
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE (plus COMP between RUN and DONE when GAIN_COMP_EN is defined).
REQ-014 SHALL drive in_ready=1 only in IDLE; no new operand accepted in any other state.
REQ-015 SHALL capture on in_valid&in_ready edge: sign-extend operands to DATA_WIDTH+2, clear iteration counter, enter RUN.
REQ-016 SHALL pre-rotate at capture: x_in>=0 -> x=x_in, y=y_in, z=0; x_in<0 -> x=-x_in, y=-y_in, z=+pi (0x0C910) if y_in>=0 else -pi (0x336F0).
REQ-017 SHALL perform iteration i per RUN cycle: y>=0 -> x+=y>>>i, y-=x>>>i, z+=atan(i); y<0 -> x-=y>>>i, y+=x>>>i, z-=atan(i); shifts arithmetic, using pre-update x,y.
REQ-018 SHALL leave RUN after iteration ITER-1; out_valid rises exactly ITER cycles after the accept edge (ITER+1 with GAIN_COMP_EN).
REQ-019 SHALL hold out_valid, mag_out, ang_out stable in DONE until out_ready=1; transfer edge returns to IDLE.
REQ-020 SHALL allow out_ready high before out_valid; transfer occurs on first edge with both high.
REQ-021 SHALL give x_in=y_in=0 -> mag_out=0, ang_out=0.
REQ-022 SHALL handle x_in=-2^(DATA_WIDTH-1) without overflow (negation in extended width).
REQ-023 SHALL ignore in_valid outside IDLE; operands not sampled.

Reset
REQ-024 SHALL on rst_n=0 asynchronously force state IDLE, counter 0, in_ready=1 after release, out_valid=0, mag_out=0, ang_out=0, x/y/z registers 0.
REQ-025 SHALL abort any RUN/DONE/COMP operation on reset; no result emitted afterwards.

Configuration
REQ-026 SHALL use macro GAIN_COMP_EN to select CORDIC gain compensation.
REQ-027 SHALL, with GAIN_COMP_EN defined, add one COMP cycle multiplying final x by 0x9B75 (1/K, Q0.16), rounding to nearest, so mag_out ~= true magnitude.
REQ-028 SHALL, without GAIN_COMP_EN, output final x unscaled (gain K ~= 1.6468) and omit COMP state and multiplier.

Verification
REQ-029 SHALL cover x_in=0x4000,y_in=0 -> ang_out 0 (+-4 LSB); mag_out 26981 (+-8) without macro, 16384 (+-8) with macro; out_valid 16 cycles after accept (17 with macro).
REQ-030 SHALL cover x_in=0x4000,y_in=0x4000 -> ang_out 0x03244 (+-4 LSB).
REQ-031 SHALL cover x_in=0xC000 (-1.0),y_in=0 -> ang_out 0x0C910 (+-4 LSB); x_in=0,y_in=0xC000 -> ang_out 0x39B78 (-pi/2, +-4 LSB).
REQ-032 SHALL cover out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; transfer on out_ready rise, in_ready=1 next cycle.
REQ-033 SHALL cover rst_n pulsed low at iteration 7 -> out_valid=0 immediately, in_ready=1 after release, next operation correct.
